// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, WIDTH-parametrised, signed or unsigned operands.
// One Booth step per clock; start/busy/done handshake with a registered product.
module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // One guard bit keeps -2^(WIDTH-1) and full-range unsigned operands exact.
    localparam int W1 = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [W1-1:0]       a_r;
    logic [W1-1:0]       q_r;
    logic [W1-1:0]       m_r;
    logic                q_m1_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*WIDTH-1:0]  prod_r;
    logic                busy_r;
    logic                done_r;
    logic [W1-1:0]       t_s;
    logic [2*W1:0]       shift_s;

    function automatic logic [W1-1:0] ext_op(input logic sgn, input logic [WIDTH-1:0] x);
        ext_op = {sgn & x[WIDTH-1], x};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Booth add/subtract followed by the combined arithmetic right shift of {T,Q,q_m1}.
    always_comb begin
        t_s = a_r;
        case ({q_r[0], q_m1_r})
            2'b10:   t_s = a_r - m_r;
            2'b01:   t_s = a_r + m_r;
            default: t_s = a_r;
        endcase
        shift_s = {t_s[W1-1], t_s, q_r};
    end

    // Datapath registers: operand load in IDLE, one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            q_r    <= '0;
            m_r    <= '0;
            q_m1_r <= 1'b0;
            cnt_r  <= '0;
            prod_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r    <= '0;
                        q_r    <= ext_op(signed_mode, multiplier);
                        m_r    <= ext_op(signed_mode, multiplicand);
                        q_m1_r <= 1'b0;
                        cnt_r  <= CNT_LOAD;
                    end
                end
                ST_RUN: begin
                    a_r    <= shift_s[2*W1 -: W1];
                    q_r    <= shift_s[W1 -: W1];
                    q_m1_r <= shift_s[0];
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        prod_r <= shift_s[2*WIDTH:1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= (state_nx_s == ST_DONE);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = prod_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: scoreboarded WIDTH=8 instance plus WIDTH=4/16 sweep instances.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, sm;
    logic [7:0]  mc, mp;
    logic        busy, done;
    logic [15:0] product;

    logic        start4, sm4, busy4, done4;
    logic [3:0]  mc4, mp4;
    logic [7:0]  prod4;

    logic        start16, sm16, busy16, done16;
    logic [15:0] mc16, mp16;
    logic [31:0] prod16;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .multiplicand(mc), .multiplier(mp),
        .busy(busy), .done(done), .product(product)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .multiplicand(mc4), .multiplier(mp4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .multiplicand(mc16), .multiplier(mp16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned ref_mul(input int w, input bit s,
                                                input longint unsigned a, input longint unsigned b);
        longint sa, sb;
        longint unsigned mask;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return $unsigned(sa * sb) & mask;
    endfunction

    // Scoreboard and cycle model of the WIDTH=8 instance.
    logic [15:0] sb[$];
    logic [15:0] pending_exp;
    logic [15:0] exp_prod;
    int          mcnt;
    bit          r_smp, st_smp;
    logic [15:0] pe_smp;

    initial begin
        mcnt     = 0;
        exp_prod = 16'h0000;
        forever begin
            @(posedge clk);
            r_smp  = rst;
            st_smp = start;
            pe_smp = pending_exp;
            if (r_smp) begin
                mcnt = 0;
                sb.delete();
                exp_prod = 16'h0000;
            end else if (mcnt == 0) begin
                if (st_smp) begin
                    sb.push_back(pe_smp);
                    mcnt = 10;
                end
            end else begin
                mcnt--;
            end
            @(negedge clk);
            chk("busy", busy, (mcnt != 0));
            chk("done", done, (mcnt == 1));
            if (mcnt == 1) begin
                chk("sb_depth", sb.size(), 1);
                if (sb.size() > 0) exp_prod = sb.pop_front();
            end
            chk("product", product, exp_prod);
        end
    end

    task automatic wait_idle8();
        do begin
            @(posedge clk);
            #2;
        end while (mcnt != 0);
    endtask

    task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
        wait_idle8();
        sm = s; mc = a; mp = b; pending_exp = e; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run4(input bit s, input logic [3:0] a, input logic [3:0] b);
        int n;
        logic [7:0] e;
        e = 8'(ref_mul(4, s, 64'(a), 64'(b)));
        @(posedge clk);
        #1 sm4 = s; mc4 = a; mp4 = b; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done4 && n < 8);
        chk("lat4", n, 5);
        chk("prod4", prod4, e);
        @(negedge clk);
        chk("done4_width", done4, 0);
    endtask

    task automatic run16(input bit s, input logic [15:0] a, input logic [15:0] b);
        int n;
        logic [31:0] e;
        e = 32'(ref_mul(16, s, 64'(a), 64'(b)));
        @(posedge clk);
        #1 sm16 = s; mc16 = a; mp16 = b; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done16 && n < 20);
        chk("lat16", n, 17);
        chk("prod16", prod16, e);
        @(negedge clk);
        chk("done16_width", done16, 0);
    endtask

    typedef struct {
        bit          s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit          s;
        logic [7:0]  a, b;
        rst = 1'b1; start = 1'b0; sm = 1'b0; mc = 8'h00; mp = 8'h00; pending_exp = 16'h0000;
        start4 = 1'b0; sm4 = 1'b0; mc4 = 4'h0; mp4 = 4'h0;
        start16 = 1'b0; sm16 = 1'b0; mc16 = 16'h0000; mp16 = 16'h0000;

        tbl[0] = '{1'b1, 8'd7,  8'hFD, 16'hFFEB};
        tbl[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tbl[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        tbl[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        tbl[4] = '{1'b0, 8'd0,  8'd200, 16'h0000};
        tbl[5] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        tbl[6] = '{1'b0, 8'd12, 8'd11, 16'h0084};
        tbl[7] = '{1'b1, 8'h80, 8'h01, 16'hFF80};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            op8(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp);
        end

        // start held high with operands changing every cycle
        wait_idle8();
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            sm = s; mc = a; mp = b; start = 1'b1;
            pending_exp = 16'(ref_mul(8, s, 64'(a), 64'(b)));
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        // reset in the middle of a run, then a clean multiply
        wait_idle8();
        sm = 1'b1; mc = 8'd100; mp = 8'd77; pending_exp = 16'(ref_mul(8, 1'b1, 64'd100, 64'd77));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        op8(1'b0, 8'd12, 8'd11, 16'h0084);

        for (int i = 0; i < 100; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            op8(s, a, b, 16'(ref_mul(8, s, 64'(a), 64'(b))));
        end
        wait_idle8();

        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run4(1'(m), 4'(x), 4'(y));
                end
            end
        end

        for (int i = 0; i < 1000; i++) begin
            run16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end
        run16(1'b1, 16'h8000, 16'h8000);
        run16(1'b0, 16'hFFFF, 16'hFFFF);

        wait_idle8();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
